// File: rtl/player_lives_manager.sv
// -----------------------------------------------------------------------------
// player_lives_manager
//
// Tracks the player's remaining lives and the invulnerability window that
// follows a hit. Raw collision flags become a clean one-cycle player_hit
// pulse for the game state machine. The block also drives the sprite blink
// shown while the player is invulnerable. Everything runs on pixel_clk.
//
// Parameters
//   START_LIVES    lives loaded on the start screen (1..3)
//   INVULN_FRAMES  frames of invulnerability after a non-fatal hit (1..255)
//
// Ports
//   pixel_clk             in   pixel clock
//   rst                   in   asynchronous, active-high reset
//   fsync                 in   one-cycle pulse, once per frame
//   game_state            in   0 START_SCREEN, 1 NEXT_LEVEL, 2 PLAY_GAME,
//                              3 GAMEOVER_SCREEN
//   bullet_hit_player     in   level flag from the bullet/player collision check
//   alien_reached_paddle  in   level flag, an alien reached the player row
//   player_hit            out  one-cycle pulse per accepted hit
//   lives_remaining       out  current lives (registered)
//   invulnerable          out  high while bullet hits are ignored
//   player_visible        out  sprite enable, blinks during invulnerability
// -----------------------------------------------------------------------------
module player_lives_manager #(
   parameter int START_LIVES   = 3,
   parameter int INVULN_FRAMES = 120
) (
   input  logic       pixel_clk,
   input  logic       rst,
   input  logic       fsync,
   input  logic [1:0] game_state,
   input  logic       bullet_hit_player,
   input  logic       alien_reached_paddle,
   output logic       player_hit,
   output logic [1:0] lives_remaining,
   output logic       invulnerable,
   output logic       player_visible
);

   // Encoding of the game_state input driven by the game state machine.
   localparam logic [1:0] GS_START_SCREEN    = 2'd0;
   localparam logic [1:0] GS_NEXT_LEVEL      = 2'd1;
   localparam logic [1:0] GS_PLAY_GAME       = 2'd2;
   localparam logic [1:0] GS_GAMEOVER_SCREEN = 2'd3;

   localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
   localparam logic [7:0] INV_LOAD   = 8'(INVULN_FRAMES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ALIVE  = 2'd1,
      INVULN = 2'd2,
      DEAD   = 2'd3
   } state_t;

   // Registered state.
   state_t     state;
   logic [7:0] inv_cnt;
   logic       bullet_prev;

   // Next-state values.
   state_t     state_n;
   logic [7:0] inv_cnt_n;
   logic [1:0] lives_n;
   logic       hit_n;
   logic       invulnerable_n;
   logic       visible_n;

   // A bullet counts only on its rising edge, so a flag held high across
   // frames (or across invulnerability expiry) costs at most one life.
   logic bullet_edge;
   assign bullet_edge = bullet_hit_player & ~bullet_prev;

   // --------------------------------------------------------------------------
   // Next-state and output logic
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default first so no path through the case
      // statements leaves one unassigned, which would infer a latch.
      state_n   = state;
      inv_cnt_n = inv_cnt;
      lives_n   = lives_remaining;
      hit_n     = 1'b0;

      // game_state overrides hit handling in every FSM state.
      case (game_state)
         GS_START_SCREEN: begin
            state_n   = IDLE;
            lives_n   = LIVES_INIT;
            inv_cnt_n = 8'd0;
         end

         GS_GAMEOVER_SCREEN: begin
            state_n   = IDLE;
            inv_cnt_n = 8'd0;
         end

         GS_NEXT_LEVEL: begin
            // A new level starts the player fresh; a dead player stays dead.
            if (state == INVULN) begin
               state_n   = ALIVE;
               inv_cnt_n = 8'd0;
            end
         end

         GS_PLAY_GAME: begin
            case (state)
               IDLE: begin
                  state_n = ALIVE;
               end

               ALIVE: begin
                  // The paddle rule wins over a simultaneous bullet edge.
                  if (alien_reached_paddle) begin
                     state_n = DEAD;
                     lives_n = 2'd0;
                     hit_n   = 1'b1;
                  end else if (bullet_edge) begin
                     hit_n = 1'b1;
                     if (lives_remaining > 2'd1) begin
                        lives_n   = lives_remaining - 2'd1;
                        state_n   = INVULN;
                        inv_cnt_n = INV_LOAD;
                     end else begin
                        // Covers lives==0 too, so lives never wrap.
                        lives_n = 2'd0;
                        state_n = DEAD;
                     end
                  end
               end

               INVULN: begin
                  // Invulnerability shields against bullets only.
                  if (alien_reached_paddle) begin
                     state_n   = DEAD;
                     lives_n   = 2'd0;
                     hit_n     = 1'b1;
                     inv_cnt_n = 8'd0;
                  end else if (fsync) begin
                     if (inv_cnt <= 8'd1) begin
                        state_n   = ALIVE;
                        inv_cnt_n = 8'd0;
                     end else begin
                        inv_cnt_n = inv_cnt - 8'd1;
                     end
                  end
               end

               DEAD: begin
                  // Nothing is accepted until the game leaves PLAY_GAME.
               end
            endcase
         end
      endcase

      // Outputs are decoded from the next state so they register on the
      // same edge as the state itself.
      invulnerable_n = (state_n == INVULN);
      if (state_n == INVULN) begin
         visible_n = inv_cnt_n[3];
      end else if (state_n == DEAD) begin
         visible_n = 1'b0;
      end else begin
         visible_n = 1'b1;
      end
   end

   // --------------------------------------------------------------------------
   // State and output registers
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         inv_cnt         <= 8'd0;
         bullet_prev     <= 1'b0;
         lives_remaining <= LIVES_INIT;
         player_hit      <= 1'b0;
         invulnerable    <= 1'b0;
         player_visible  <= 1'b1;
      end else begin
         state           <= state_n;
         inv_cnt         <= inv_cnt_n;
         bullet_prev     <= bullet_hit_player;
         lives_remaining <= lives_n;
         player_hit      <= hit_n;
         invulnerable    <= invulnerable_n;
         player_visible  <= visible_n;
      end
   end

endmodule

// File: tb/tb_player_lives_manager.sv
// -----------------------------------------------------------------------------
// tb_player_lives_manager
//
// Directed bench for player_lives_manager with default parameters
// (START_LIVES=3, INVULN_FRAMES=120). Inputs change 1 ns after a rising
// edge; outputs are compared at the same point, after the edge that sampled
// the preceding inputs.
// -----------------------------------------------------------------------------
module tb_player_lives_manager;

   logic       pixel_clk = 1'b0;
   logic       rst = 1'b0;
   logic       fsync = 1'b0;
   logic [1:0] game_state = 2'd0;
   logic       bullet_hit_player = 1'b0;
   logic       alien_reached_paddle = 1'b0;
   logic       player_hit;
   logic [1:0] lives_remaining;
   logic       invulnerable;
   logic       player_visible;

   int pass_cnt = 0;
   int total_cnt = 0;

   player_lives_manager #(
      .START_LIVES  (3),
      .INVULN_FRAMES(120)
   ) dut (
      .pixel_clk           (pixel_clk),
      .rst                 (rst),
      .fsync               (fsync),
      .game_state          (game_state),
      .bullet_hit_player   (bullet_hit_player),
      .alien_reached_paddle(alien_reached_paddle),
      .player_hit          (player_hit),
      .lives_remaining     (lives_remaining),
      .invulnerable        (invulnerable),
      .player_visible      (player_visible)
   );

   always #5 pixel_clk = ~pixel_clk;

   typedef struct {
      string      name;
      logic [1:0] gs;
      logic       bullet;
      logic       paddle;
      logic       fs;
      logic       exp_hit;
      logic [1:0] exp_lives;
      logic       exp_inv;
      logic       exp_vis;
   } vec_t;

   task automatic check(input string name, input int actual, input int expected);
      total_cnt++;
      if (actual == expected) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic check_outs(input string name, input logic hit, input logic [1:0] lives,
                             input logic inv, input logic vis);
      check({name, ".hit"},   int'(player_hit),      int'(hit));
      check({name, ".lives"}, int'(lives_remaining), int'(lives));
      check({name, ".inv"},   int'(invulnerable),    int'(inv));
      check({name, ".vis"},   int'(player_visible),  int'(vis));
   endtask

   task automatic step();
      @(posedge pixel_clk);
      #1;
   endtask

   task automatic do_reset();
      fsync = 1'b0;
      game_state = 2'd0;
      bullet_hit_player = 1'b0;
      alien_reached_paddle = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Reset, start screen, then PLAY_GAME so the FSM sits in ALIVE with 3 lives.
   task automatic enter_play();
      do_reset();
      game_state = 2'd0;
      step();
      game_state = 2'd2;
      step();
   endtask

   // Runs a full 120-frame invulnerability window and checks every frame
   // against a counter model. Optionally raises the bullet on the expiring
   // fsync cycle; it is then left high.
   task automatic countdown(input string name, input logic [1:0] lives, input bit bullet_at_expiry);
      logic [7:0] cnt_m;
      cnt_m = 8'd120;
      for (int f = 0; f < 120; f++) begin
         fsync = 1'b1;
         if (bullet_at_expiry && f == 119) bullet_hit_player = 1'b1;
         step();
         fsync = 1'b0;
         cnt_m = cnt_m - 8'd1;
         check_outs($sformatf("%s.f%0d", name, f + 1), 1'b0, lives,
                    cnt_m != 8'd0, (cnt_m != 8'd0) ? cnt_m[3] : 1'b1);
         for (int k = 0; k < 3; k++) step();
      end
   endtask

   vec_t vecs[$];

   initial begin
      int hits;

      // --- table-driven vectors, applied back to back from reset ----------
      vecs.push_back('{"start",       2'd0, 0, 0, 0, 0, 2'd3, 0, 1});
      vecs.push_back('{"play",        2'd2, 0, 0, 0, 0, 2'd3, 0, 1});
      vecs.push_back('{"bullet1",     2'd2, 1, 0, 0, 1, 2'd2, 1, 1});
      vecs.push_back('{"bullet_low",  2'd2, 0, 0, 0, 0, 2'd2, 1, 1});
      vecs.push_back('{"inv_edge",    2'd2, 1, 0, 0, 0, 2'd2, 1, 1});
      vecs.push_back('{"inv_fsync",   2'd2, 1, 0, 1, 0, 2'd2, 1, 0});
      vecs.push_back('{"next_lvl",    2'd1, 0, 0, 0, 0, 2'd2, 0, 1});
      vecs.push_back('{"nl_bullet",   2'd1, 1, 0, 0, 0, 2'd2, 0, 1});
      vecs.push_back('{"play_again",  2'd2, 0, 0, 0, 0, 2'd2, 0, 1});
      vecs.push_back('{"paddle",      2'd2, 0, 1, 0, 1, 2'd0, 0, 0});
      vecs.push_back('{"paddle_held", 2'd2, 0, 1, 0, 0, 2'd0, 0, 0});
      vecs.push_back('{"dead_bullet", 2'd2, 1, 0, 0, 0, 2'd0, 0, 0});
      vecs.push_back('{"gameover",    2'd3, 0, 0, 0, 0, 2'd0, 0, 1});
      vecs.push_back('{"reload",      2'd0, 0, 0, 0, 0, 2'd3, 0, 1});

      do_reset();
      check_outs("reset", 1'b0, 2'd3, 1'b0, 1'b1);

      foreach (vecs[i]) begin
         game_state           = vecs[i].gs;
         bullet_hit_player    = vecs[i].bullet;
         alien_reached_paddle = vecs[i].paddle;
         fsync                = vecs[i].fs;
         step();
         check_outs(vecs[i].name, vecs[i].exp_hit, vecs[i].exp_lives,
                    vecs[i].exp_inv, vecs[i].exp_vis);
      end

      // --- three spaced hits with full invulnerability windows ------------
      enter_play();
      bullet_hit_player = 1'b1;
      step();
      check_outs("hit1", 1'b1, 2'd2, 1'b1, 1'b1);
      bullet_hit_player = 1'b0;
      step();
      check_outs("hit1_end", 1'b0, 2'd2, 1'b1, 1'b1);
      // Bullet rises on the expiring fsync: ignored, and stays high.
      countdown("cd1", 2'd2, 1'b1);
      check_outs("held_after_exp", 1'b0, 2'd2, 1'b0, 1'b1);
      bullet_hit_player = 1'b0;
      step();
      bullet_hit_player = 1'b1;
      step();
      check_outs("hit2", 1'b1, 2'd1, 1'b1, 1'b1);
      bullet_hit_player = 1'b0;
      step();
      countdown("cd2", 2'd1, 1'b0);
      bullet_hit_player = 1'b1;
      step();
      check_outs("hit3", 1'b1, 2'd0, 1'b0, 1'b0);
      bullet_hit_player = 1'b0;
      step();
      bullet_hit_player = 1'b1;
      step();
      check_outs("hit_after_dead", 1'b0, 2'd0, 1'b0, 1'b0);

      // --- bullet held for 500 cycles: one pulse, one decrement -----------
      enter_play();
      hits = 0;
      bullet_hit_player = 1'b1;
      for (int c = 0; c < 500; c++) begin
         step();
         if (player_hit) hits++;
      end
      check("held500.pulses", hits, 1);
      check("held500.lives", int'(lives_remaining), 2);
      // Fresh bullet pulses during INVULN draw no response.
      hits = 0;
      for (int c = 0; c < 6; c++) begin
         bullet_hit_player = c[0];
         step();
         if (player_hit) hits++;
      end
      check("inv_pulses", hits, 0);

      // --- paddle together with a bullet edge during INVULN, lives=2 ------
      bullet_hit_player = 1'b0;
      step();
      bullet_hit_player = 1'b1;
      alien_reached_paddle = 1'b1;
      step();
      check_outs("paddle_inv", 1'b1, 2'd0, 1'b0, 1'b0);
      hits = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (player_hit) hits++;
      end
      check("paddle_inv.extra", hits, 0);
      bullet_hit_player = 1'b0;
      alien_reached_paddle = 1'b0;

      // --- NEXT_LEVEL mid-INVULN -------------------------------------------
      enter_play();
      bullet_hit_player = 1'b1;
      step();
      bullet_hit_player = 1'b0;
      step();
      check_outs("pre_nl", 1'b0, 2'd2, 1'b1, 1'b1);
      game_state = 2'd1;
      step();
      check_outs("nl_mid_inv", 1'b0, 2'd2, 1'b0, 1'b1);
      game_state = 2'd0;
      step();
      check_outs("nl_reload", 1'b0, 2'd3, 1'b0, 1'b1);

      // --- asynchronous reset during INVULN and mid-pulse ------------------
      game_state = 2'd2;
      step();
      bullet_hit_player = 1'b1;
      step();
      check_outs("pre_rst", 1'b1, 2'd2, 1'b1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_outs("async_rst", 1'b0, 2'd3, 1'b0, 1'b1);
      step();
      rst = 1'b0;
      bullet_hit_player = 1'b0;
      step();
      check_outs("post_rst", 1'b0, 2'd3, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
